alu_key_ctrl: RTL and testbench

ALU_KEY_CTRL -- requirements
Module: alu_key_ctrl

---
 rtl/alu_key_ctrl.sv | 127 ++++++++++++
 tb/tb_alu_key_ctrl.sv | 325 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_key_ctrl.sv
// alu_key_ctrl: debounced load-button controller for a small ALU.
// Synchronizes the raw pushbuttons and switches, qualifies KEY[0] presses
// and releases over DB_CYCLES stable samples, and on each accepted press
// latches opcode/operand and issues a one-cycle load or clear strobe.
module alu_key_ctrl #(
    parameter int DB_CYCLES = 500000
) (
    input  logic       CLOCK_50,
    input  logic       resetn,
    input  logic [3:0] KEY,
    input  logic [9:0] SW,
    output logic [2:0] op,
    output logic [3:0] data,
    output logic       load,
    output logic       clr,
    output logic [7:0] press_cnt
);

    localparam int DBW = $clog2(DB_CYCLES);
    localparam logic [DBW-1:0] DB_LAST = DBW'(DB_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE,
        DB_PRESS,
        HELD,
        DB_RELEASE
    } state_t;

    state_t         state;
    logic [DBW-1:0] dbc;

    // synchronizer stages; keys idle high, switches idle low
    logic [3:0] key_s1, key_s2;
    logic       sw9_s1, sw9_s2;
    logic [3:0] swd_s1, swd_s2;

    logic k0;
    assign k0 = ~key_s2[0];

    // SW[8:4] have no function in this block
    logic unused_sw;
    assign unused_sw = ^SW[8:4];

    // two-flop synchronizers on every raw input that is used
    always_ff @(posedge CLOCK_50 or negedge resetn) begin
        if (!resetn) begin
            key_s1 <= 4'hF;
            key_s2 <= 4'hF;
            sw9_s1 <= 1'b0;
            sw9_s2 <= 1'b0;
            swd_s1 <= 4'h0;
            swd_s2 <= 4'h0;
        end else begin
            key_s1 <= KEY;
            key_s2 <= key_s1;
            sw9_s1 <= SW[9];
            sw9_s2 <= sw9_s1;
            swd_s1 <= SW[3:0];
            swd_s2 <= swd_s1;
        end
    end

    // debounce FSM; the accept edge also registers op/data/strobes/count
    always_ff @(posedge CLOCK_50 or negedge resetn) begin
        if (!resetn) begin
            state     <= IDLE;
            dbc       <= '0;
            op        <= 3'b000;
            data      <= 4'h0;
            load      <= 1'b0;
            clr       <= 1'b0;
            press_cnt <= 8'd0;
        end else begin
            // strobes are single-cycle unless re-armed below
            load <= 1'b0;
            clr  <= 1'b0;
            case (state)
                IDLE: begin
                    if (k0) begin
                        state <= DB_PRESS;
                        dbc   <= '0;
                    end
                end
                DB_PRESS: begin
                    if (!k0) begin
                        // bounce: drop back without any strobe
                        state <= IDLE;
                        dbc   <= '0;
                    end else if (dbc == DB_LAST) begin
                        state     <= HELD;
                        dbc       <= '0;
                        load      <= sw9_s2;
                        clr       <= ~sw9_s2;
                        op        <= ~key_s2[3:1];
                        data      <= swd_s2;
                        press_cnt <= press_cnt + 8'd1;
                    end else begin
                        dbc <= dbc + DBW'(1);
                    end
                end
                HELD: begin
                    if (!k0) begin
                        state <= DB_RELEASE;
                        dbc   <= '0;
                    end
                end
                DB_RELEASE: begin
                    if (k0) begin
                        // release bounce: still the same press
                        state <= HELD;
                        dbc   <= '0;
                    end else if (dbc == DB_LAST) begin
                        state <= IDLE;
                        dbc   <= '0;
                    end else begin
                        dbc <= dbc + DBW'(1);
                    end
                end
                default: begin
                    state <= IDLE;
                    dbc   <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_key_ctrl.sv
// tb_alu_key_ctrl: directed and randomized checks of alu_key_ctrl with
// DB_CYCLES=4 against a run-length reference model.
module tb_alu_key_ctrl;

    localparam int DB = 4;

    logic       clk;
    logic       resetn;
    logic [3:0] KEY;
    logic [9:0] SW;
    logic [2:0] op;
    logic [3:0] data;
    logic       load;
    logic       clr;
    logic [7:0] press_cnt;

    int checks = 0;
    int errors = 0;

    alu_key_ctrl #(.DB_CYCLES(DB)) dut (
        .CLOCK_50 (clk),
        .resetn   (resetn),
        .KEY      (KEY),
        .SW       (SW),
        .op       (op),
        .data     (data),
        .load     (load),
        .clr      (clr),
        .press_cnt(press_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: inputs seen two clocks late; a press (release) is
    // accepted on the (DB+1)-th consecutive sample that disagrees with the
    // current accepted level, any agreeing sample restarts the run.
    logic [3:0] kh1, kh2;
    logic       s9h1, s9h2;
    logic [3:0] sdh1, sdh2;
    logic       m_held;
    int         m_run;
    logic [2:0] m_op;
    logic [3:0] m_data;
    logic       m_load, m_clr;
    logic [7:0] m_cnt;

    always @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            kh1 <= 4'hF; kh2 <= 4'hF;
            s9h1 <= 1'b0; s9h2 <= 1'b0;
            sdh1 <= 4'h0; sdh2 <= 4'h0;
            m_held <= 1'b0; m_run <= 0;
            m_op <= 3'd0; m_data <= 4'd0;
            m_load <= 1'b0; m_clr <= 1'b0; m_cnt <= 8'd0;
        end else begin
            kh1 <= KEY; kh2 <= kh1;
            s9h1 <= SW[9]; s9h2 <= s9h1;
            sdh1 <= SW[3:0]; sdh2 <= sdh1;
            m_load <= 1'b0;
            m_clr  <= 1'b0;
            if (m_held == kh2[0]) begin
                // sample disagrees with accepted level (held & up, or idle & down)
                if (m_run == DB) begin
                    m_run  <= 0;
                    m_held <= ~m_held;
                    if (!m_held) begin
                        m_load <= s9h2;
                        m_clr  <= ~s9h2;
                        m_op   <= ~kh2[3:1];
                        m_data <= sdh2;
                        m_cnt  <= (m_cnt == 8'd255) ? 8'd0 : m_cnt + 8'd1;
                    end
                end else begin
                    m_run <= m_run + 1;
                end
            end else begin
                m_run <= 0;
            end
        end
    end

    logic [16:0] dut_v, mdl_v;
    assign dut_v = {op, data, load, clr, press_cnt};
    assign mdl_v = {m_op, m_data, m_load, m_clr, m_cnt};

    task automatic tick;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_reset;
        resetn = 1'b0;
        tick();
        tick();
        resetn = 1'b1;
    endtask

    task automatic test_reset;
        resetn = 1'b0;
        KEY = 4'hF;
        SW = 10'h000;
        #2;
        checks++;
        if (dut_v !== 17'd0) begin
            errors++;
            $display("FAIL reset_outputs got %h exp %h", dut_v, 17'd0);
        end
        tick();
        tick();
        resetn = 1'b1;
        for (int t = 1; t <= 6; t++) begin
            tick();
            checks++;
            if (dut_v !== 17'd0) begin
                errors++;
                $display("FAIL reset_idle cyc %0d got %h exp %h", t, dut_v, 17'd0);
            end
        end
    endtask

    // clean press; sw9 selects load vs clear path
    task automatic test_press(input logic sw9);
        KEY = 4'hF;
        do_reset();
        KEY = 4'b1010;
        SW = {sw9, 9'h00B};
        for (int t = 1; t <= 14; t++) begin
            tick();
            checks++;
            if (dut_v !== mdl_v) begin
                errors++;
                $display("FAIL press_model sw9=%0b cyc %0d got %h exp %h", sw9, t, dut_v, mdl_v);
            end
            checks++;
            if ({load, clr} !== (t == 7 ? {sw9, ~sw9} : 2'b00)) begin
                errors++;
                $display("FAIL press_strobe sw9=%0b cyc %0d got %b exp %b", sw9, t, {load, clr},
                         (t == 7 ? {sw9, ~sw9} : 2'b00));
            end
            // after acceptance, wiggle everything except the load button
            if (t >= 7) begin
                KEY = {3'($urandom), 1'b0};
                SW = 10'($urandom);
            end
        end
        checks++;
        if ({op, data, press_cnt} !== {3'b010, 4'hB, 8'd1}) begin
            errors++;
            $display("FAIL press_latched sw9=%0b got %h exp %h", sw9, {op, data, press_cnt},
                     {3'b010, 4'hB, 8'd1});
        end
        KEY = 4'hF;
        repeat (8) tick();
    endtask

    task automatic test_bounce;
        int nl;
        int at;
        nl = 0;
        at = 0;
        KEY = 4'hF;
        SW = 10'h205;
        do_reset();
        for (int t = 1; t <= 16; t++) begin
            KEY[0] = (t == 4) ? 1'b1 : 1'b0;
            tick();
            if (load) begin
                nl++;
                at = t;
            end
            checks++;
            if (dut_v !== mdl_v) begin
                errors++;
                $display("FAIL bounce_model cyc %0d got %h exp %h", t, dut_v, mdl_v);
            end
        end
        checks++;
        if (nl !== 1 || at !== 11) begin
            errors++;
            $display("FAIL bounce_strobe got n=%0d at=%0d exp n=1 at=11", nl, at);
        end
        KEY = 4'hF;
        repeat (8) tick();
    endtask

    task automatic test_hold_release;
        int nl1;
        int at2;
        nl1 = 0;
        at2 = 0;
        KEY = 4'hF;
        SW = 10'h203;
        do_reset();
        for (int t = 1; t <= 70; t++) begin
            if (t <= 50) KEY[0] = (t == 20 || t == 35);
            else if (t <= 56) KEY[0] = 1'b1;
            else KEY[0] = 1'b0;
            tick();
            if (load && t <= 56) nl1++;
            if (load && t > 56) at2 = t;
            checks++;
            if (dut_v !== mdl_v) begin
                errors++;
                $display("FAIL hold_model cyc %0d got %h exp %h", t, dut_v, mdl_v);
            end
        end
        checks++;
        if (nl1 !== 1) begin
            errors++;
            $display("FAIL hold_single got %0d exp 1", nl1);
        end
        checks++;
        if (at2 !== 63) begin
            errors++;
            $display("FAIL release_idle got %0d exp 63", at2);
        end
        checks++;
        if (press_cnt !== 8'd2) begin
            errors++;
            $display("FAIL hold_count got %0d exp 2", press_cnt);
        end
        KEY = 4'hF;
        repeat (8) tick();
    endtask

    task automatic test_wrap;
        KEY = 4'hF;
        SW = 10'h20B;
        do_reset();
        for (int p = 1; p <= 257; p++) begin
            for (int t = 1; t <= 14; t++) begin
                KEY = (t <= 7) ? 4'b1010 : 4'b1011;
                tick();
                checks++;
                if (dut_v !== mdl_v) begin
                    errors++;
                    $display("FAIL wrap_model press %0d cyc %0d got %h exp %h", p, t, dut_v, mdl_v);
                end
            end
            if (p == 256) begin
                checks++;
                if (press_cnt !== 8'd0) begin
                    errors++;
                    $display("FAIL wrap_256 got %0d exp 0", press_cnt);
                end
            end
        end
        checks++;
        if (press_cnt !== 8'd1) begin
            errors++;
            $display("FAIL wrap_257 got %0d exp 1", press_cnt);
        end
        KEY = 4'hF;
        repeat (8) tick();
    endtask

    // relies on op/data/press_cnt being nonzero from the previous test
    task automatic test_reset_mid;
        int at;
        at = 0;
        KEY = 4'b1010;
        SW = 10'h20B;
        repeat (5) tick();
        resetn = 1'b0;
        #1;
        checks++;
        if (dut_v !== 17'd0) begin
            errors++;
            $display("FAIL reset_mid_clear got %h exp %h", dut_v, 17'd0);
        end
        tick();
        tick();
        resetn = 1'b1;
        for (int t = 1; t <= 12; t++) begin
            tick();
            if (load) at = t;
            checks++;
            if (dut_v !== mdl_v) begin
                errors++;
                $display("FAIL reset_mid_model cyc %0d got %h exp %h", t, dut_v, mdl_v);
            end
        end
        checks++;
        if (at !== 7) begin
            errors++;
            $display("FAIL reset_mid_requal got %0d exp 7", at);
        end
        KEY = 4'hF;
        repeat (8) tick();
    endtask

    task automatic test_random;
        KEY = 4'hF;
        SW = 10'h000;
        do_reset();
        for (int t = 1; t <= 3000; t++) begin
            KEY[3:1] = 3'($urandom);
            SW = 10'($urandom);
            if ($urandom_range(0, 5) == 0) KEY[0] = ~KEY[0];
            tick();
            checks++;
            if (dut_v !== mdl_v) begin
                errors++;
                $display("FAIL random_model cyc %0d got %h exp %h", t, dut_v, mdl_v);
            end
        end
        KEY = 4'hF;
        repeat (8) tick();
    endtask

    initial begin
        test_reset();
        test_press(1'b1);
        test_press(1'b0);
        test_bounce();
        test_hold_release();
        test_wrap();
        test_reset_mid();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
